// File: rtl/au_filter_sched.sv
// Round-robin scheduler that chains PCM samples through a shared biquad MAC datapath.
// Optional watchdog on datapath completion: define AU_SCHED_WATCHDOG_EN.
module au_filter_sched #(
  parameter int NumChannels = 2,
  parameter int NumStages   = 4,
  parameter int SampleWidth = 16
`ifdef AU_SCHED_WATCHDOG_EN
  , parameter int WdogCycles = 255
`endif
  , localparam int ChanW  = (NumChannels > 1) ? $clog2(NumChannels) : 1
  , localparam int StageW = (NumStages > 1) ? $clog2(NumStages) : 1
  , localparam int CntW   = $clog2(NumStages + 1)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             enable_i,
  input  logic [CntW-1:0]                  stage_count_i,
  input  logic [NumChannels-1:0]           smp_valid_i,
  input  logic [NumChannels*SampleWidth-1:0] smp_data_i,
  output logic [NumChannels-1:0]           smp_ready_o,
  output logic                             dp_start_o,
  output logic [ChanW-1:0]                 dp_chan_o,
  output logic [StageW-1:0]                dp_stage_o,
  output logic [SampleWidth-1:0]           dp_data_o,
  input  logic                             dp_done_i,
  input  logic [SampleWidth-1:0]           dp_data_i,
  output logic                             res_valid_o,
  input  logic                             res_ready_i,
  output logic [SampleWidth-1:0]           res_data_o,
  output logic [ChanW-1:0]                 res_chan_o,
  output logic                             busy_o,
  output logic                             error_o,
  output logic [1:0]                       dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [ChanW-1:0]       rr_q, chan_q, gnt_chan, scan_idx;
  logic [StageW-1:0]      stage_q;
  logic [CntW-1:0]        limit_q, limit_in;
  logic [SampleWidth-1:0] work_q, gnt_data;
  logic                   busy_q, gnt_found, grant, last_stage, timeout;

  // Handshakes: a transfer happens on a cycle where valid and ready are both high.
  // smp_ready_o is raised only in IDLE and may depend combinationally on smp_valid_i;
  // res_valid_o, once raised, holds with stable data until res_ready_i is seen.

  // Round-robin scan starts one past the last granted channel.
  always_comb begin
    gnt_found = 1'b0;
    gnt_chan  = '0;
    scan_idx  = '0;
    for (int i = 1; i <= NumChannels; i++) begin
      scan_idx = ChanW'((int'(rr_q) + i) % NumChannels);
      if (!gnt_found && |(smp_valid_i & (NumChannels'(1) << scan_idx))) begin
        gnt_found = 1'b1;
        gnt_chan  = scan_idx;
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int c = 0; c < NumChannels; c++) begin
      if (gnt_chan == ChanW'(c)) gnt_data = smp_data_i[c*SampleWidth +: SampleWidth];
    end
  end

  assign grant      = (state_q == IDLE) && enable_i && gnt_found && !rst_i;
  assign limit_in   = (stage_count_i > CntW'(NumStages)) ? CntW'(NumStages) : stage_count_i;
  assign last_stage = (CntW'(stage_q) == (limit_q - CntW'(1)));

  always_comb begin
    smp_ready_o = '0;
    for (int c = 0; c < NumChannels; c++) begin
      smp_ready_o[c] = grant && (gnt_chan == ChanW'(c));
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = (limit_in == '0) ? OUT : ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT: begin
        if (dp_done_i)    state_d = last_stage ? OUT : ISSUE;
        else if (timeout) state_d = IDLE;
      end
      OUT:     if (res_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      rr_q    <= ChanW'(NumChannels - 1);
      chan_q  <= '0;
      stage_q <= '0;
      limit_q <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      if (grant) begin
        work_q  <= gnt_data;
        chan_q  <= gnt_chan;
        rr_q    <= gnt_chan;
        limit_q <= limit_in;
        stage_q <= '0;
      end else if (state_q == WAIT && dp_done_i) begin
        work_q <= dp_data_i;
        if (!last_stage) stage_q <= stage_q + StageW'(1);
      end
    end
  end

`ifdef AU_SCHED_WATCHDOG_EN
  localparam int WdogW = $clog2(WdogCycles + 1);

  logic [WdogW-1:0] wdog_q;
  logic             err_q;

  // Done in the final allowed cycle still wins over the timeout.
  assign timeout = (state_q == WAIT) && !dp_done_i && (wdog_q == WdogW'(WdogCycles - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_d == WAIT && state_q != WAIT) wdog_q <= '0;
      else if (state_q == WAIT)               wdog_q <= wdog_q + WdogW'(1);
      if (timeout) err_q <= 1'b1;
    end
  end

  assign error_o = err_q;
`else
  assign timeout = 1'b0;
  assign error_o = 1'b0;
`endif

  assign dp_start_o  = (state_q == ISSUE);
  assign dp_chan_o   = chan_q;
  assign dp_stage_o  = stage_q;
  assign dp_data_o   = work_q;
  assign res_valid_o = (state_q == OUT);
  assign res_data_o  = work_q;
  assign res_chan_o  = chan_q;
  assign busy_o      = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/au_filter_sched.md
Name: au_filter_sched

Overview:
- Scheduler for the shared audio-filter MAC datapath in the user domain (the AuFilters subordinate at 0x2000_1000).
- Accepts PCM samples from NumChannels requesters and grants them round-robin.
- For each accepted sample, sequences the datapath through the active biquad stages, chaining each stage's result into the next.
- Presents the final filtered sample with its channel tag on a valid/ready output.

Parameters:
- NumChannels, 2, number of sample requesters (≥1)
- NumStages, 4, maximum biquad stages in the datapath (≥1)
- SampleWidth, 16, signed PCM sample width
- WdogCycles, 255, watchdog limit in cycles; used only with the optional feature

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- enable_i  in  1  allow new grants
- stage_count_i  in  $clog2(NumStages+1)  active stages, 0..NumStages; sampled at grant
- smp_valid_i  in  NumChannels  per-channel sample request
- smp_data_i  in  NumChannels*SampleWidth  per-channel samples; channel c at [c*SampleWidth +: SampleWidth]
- smp_ready_o  out  NumChannels  one-hot grant/accept
- dp_start_o  out  1  one-cycle start pulse to the datapath
- dp_chan_o  out  ChanW=max(1,$clog2(NumChannels))  channel (selects coefficient/state bank)
- dp_stage_o  out  max(1,$clog2(NumStages))  stage index
- dp_data_o  out  SampleWidth  stage operand
- dp_done_i  in  1  datapath result valid pulse
- dp_data_i  in  SampleWidth  datapath result
- res_valid_o  out  1  result valid
- res_ready_i  in  1  result accepted
- res_data_o  out  SampleWidth  filtered sample
- res_chan_o  out  ChanW  channel of the result
- busy_o  out  1  FSM not in IDLE
- error_o  out  1  sticky watchdog error

Behaviour:
- Reset values: state IDLE; all outputs 0; RR pointer = NumChannels-1, so channel 0 wins first.
- FSM states: IDLE, ISSUE, WAIT, OUT.
- IDLE grant:
  - If enable_i and any smp_valid_i, grant the first requester after the RR pointer (wrapping).
  - smp_ready_o is combinational and one-hot for the granted channel, only in IDLE.
  - Handshake completes in that same cycle. On it: latch the sample into the work register, latch chan, latch stage_count_i into the stage limit, set stage=0, set the RR pointer to chan.
  - Next state is ISSUE, or OUT if the latched stage limit is 0 (pass-through: res_data_o = input sample).
- ISSUE:
  - dp_start_o=1 for exactly one cycle; dp_chan_o/dp_stage_o/dp_data_o driven from registers.
  - These stay stable through WAIT.
  - Next state WAIT.
- WAIT:
  - On dp_done_i, capture dp_data_i into the work register.
  - If stage == limit-1, go to OUT; else stage+1 and go to ISSUE.
  - dp_done_i is ignored in every other state.
- OUT:
  - res_valid_o=1 with res_data_o=work register and res_chan_o=chan, held stable until res_ready_i.
  - On the handshake, return to IDLE. The next grant happens no earlier than the following cycle.
- Minimum per-sample latency: grant → OUT = 1 + 2·stages cycles when done arrives the cycle after start. Pass-through latency is 1 cycle.
- enable_i deasserted mid-sample: the current sample completes; no further grants.
- stage_count_i changes mid-sample: no effect until the next grant. Values > NumStages are clamped to NumStages.
- A single requester is re-granted every sample. Requesters held valid are served strictly in rotation.
- busy_o = (state != IDLE), registered.
- rst_i asserted at any time: immediate return to reset values, including the RR pointer and error_o. An in-flight sample is discarded.

Optional Feature:
- Macro: AU_SCHED_WATCHDOG_EN
- Defined:
  - An 8-bit+ counter (width $clog2(WdogCycles+1)) clears on entering WAIT and increments each WAIT cycle.
  - If it reaches WdogCycles without dp_done_i, the sample is dropped: no result, return to IDLE, error_o set sticky until reset.
  - dp_done_i and timeout in the same cycle: done wins.
- Undefined: WAIT waits indefinitely; error_o tied 0; no counter logic.

Test Plan:
- Pass-through: stage_count_i=0, ch0 sample 0x1234 → smp_ready_o=01 same cycle; res_valid_o next cycle with data 0x1234, chan 0; dp_start_o never pulses.
- Four-stage chain: stage_count_i=4, datapath model returns operand+1, done 1 cycle after start; ch1 sample 0x0010 → dp_stage_o 0,1,2,3 with dp_data_o 0x0010..0x0013; res_data_o=0x0014, res_chan_o=1, 9 cycles after grant.
- Round-robin: both channels valid continuously for 4 samples, stage_count_i=1 → grant order 0,1,0,1; each grant only after the prior result handshake.
- Backpressure: hold res_ready_i=0 for 10 cycles → res_valid_o/res_data_o stable; no new smp_ready_o; grant on the cycle after res_ready_i=1.
- Reset mid-sample: assert rst_i during WAIT of stage 2 → all outputs 0 immediately; after release, ch0 granted first even if ch1 was last.
- Watchdog (macro defined, WdogCycles=255): never assert dp_done_i → after 255 WAIT cycles error_o=1, FSM IDLE, no res_valid_o; the next sample processes normally with error_o still 1.
